// File: rtl/gate_truth_table_checker_if.sv
// Bundle of the run-control, status and gate-under-test signals of the truth table checker.
// The master side is the checker; the slave side is the environment (requester plus gate).
`timescale 1ns/1ps
interface gate_truth_table_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       y;
    logic [1:0] vec_idx;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_mask;

    modport master (
        input  start, y,
        output a, b, vec_idx, busy, done, pass, fail_mask
    );

    modport slave (
        output start, y,
        input  a, b, vec_idx, busy, done, pass, fail_mask
    );
endinterface

// File: rtl/gate_truth_table_checker.sv
// Exercises a 2-input gate through {a,b} = 00,01,10,11 and holds each vector for a settle time.
// It samples y at the end of each window, compares y against EXPECTED, and reports a mismatch mask and a pass flag.
`timescale 1ns/1ps
module gate_truth_table_checker #(
    parameter logic [3:0] EXPECTED      = 4'b0111,
    parameter int         SETTLE_CYCLES = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    gate_truth_table_checker_if.master    bus
);

    // Out-of-range settle values are clamped so the 8-bit counter always has a reachable terminal count.
    localparam int         SETTLE_EFF = (SETTLE_CYCLES < 1)   ? 1   :
                                        (SETTLE_CYCLES > 255) ? 255 : SETTLE_CYCLES;
    localparam logic [7:0] LAST_CNT   = 8'(SETTLE_EFF - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     r_state,     w_state_nxt;
    logic [7:0] r_cnt,       w_cnt_nxt;
    logic [1:0] r_vec_idx,   w_vec_idx_nxt;
    logic       r_busy,      w_busy_nxt;
    logic       r_done,      w_done_nxt;
    logic       r_pass,      w_pass_nxt;
    logic [3:0] r_fail_mask, w_fail_mask_nxt;
    logic       w_hit;
    logic [3:0] w_mask_upd;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_vec_idx_nxt   = r_vec_idx;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_pass_nxt      = r_pass;
        w_fail_mask_nxt = r_fail_mask;
        w_hit           = (bus.y != EXPECTED[r_vec_idx]);
        w_mask_upd      = r_fail_mask | ({3'b000, w_hit} << r_vec_idx);

        case (r_state)
            IDLE: begin
                w_busy_nxt    = 1'b0;
                w_vec_idx_nxt = 2'd0;
                if (bus.start) begin
                    w_state_nxt     = DRIVE;
                    w_cnt_nxt       = 8'd0;
                    w_fail_mask_nxt = 4'b0000;
                    w_pass_nxt      = 1'b0;
                    w_busy_nxt      = 1'b1;
                end
            end

            DRIVE: begin
                if (r_cnt == LAST_CNT) begin
                    w_cnt_nxt       = 8'd0;
                    w_fail_mask_nxt = w_mask_upd;
                    if (r_vec_idx == 2'd3) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_mask_upd == 4'b0000);
                    end else begin
                        w_vec_idx_nxt = r_vec_idx + 2'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end

            DONE: begin
                w_state_nxt   = IDLE;
                w_busy_nxt    = 1'b0;
                w_vec_idx_nxt = 2'd0;
            end

            default: begin
                w_state_nxt   = IDLE;
                w_busy_nxt    = 1'b0;
                w_vec_idx_nxt = 2'd0;
                w_cnt_nxt     = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 8'd0;
            r_vec_idx   <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= 4'b0000;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop updates from pre-edge values.
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_vec_idx   <= w_vec_idx_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_pass      <= w_pass_nxt;
            r_fail_mask <= w_fail_mask_nxt;
        end
    end

    assign bus.a         = r_vec_idx[1];
    assign bus.b         = r_vec_idx[0];
    assign bus.vec_idx   = r_vec_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.fail_mask = r_fail_mask;

endmodule

// File: doc/gate_truth_table_checker.md
Name: gate_truth_table_checker

Overview:
Hardware self-checking exerciser for any 2-input combinational gate in the library (nand_gate, and_gate, ...). On a start request it drives all four input vectors into the gate under test in order {a,b} = 00, 01, 10, 11. It waits a programmable settle time for each vector, then samples the gate output and compares it against a parameterised truth table. It reports a per-vector mismatch mask and a pass flag, so gate checks run on silicon or FPGA without a simulator console.

Parameters:
EXPECTED, 4'b0111, expected truth table; bit i = expected y for input index i = {a,b} (default = NAND)
SETTLE_CYCLES, 10, clock cycles each vector is held before y is sampled; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request, sampled high in IDLE only
a  output  1  gate input a (MSB of vector index)
b  output  1  gate input b (LSB of vector index)
y  input  1  gate output under test
vec_idx  output  2  index of vector currently driven
busy  output  1  high while a run is in progress
done  output  1  single-cycle pulse at end of run
pass  output  1  1 = last run had no mismatches; held until next start
fail_mask  output  4  bit i set = vector i mismatched; held until next start

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: a=0, b=0, vec_idx=0, busy=0, done=0, pass=0, fail_mask=4'b0000, FSM=IDLE, settle counter=0.
- All outputs are registered. a/b are always {a,b} = vec_idx.
- IDLE: busy=0, a=b=0.
  - start=1 on edge T: go to DRIVE, vec_idx=0, settle counter=0, fail_mask cleared to 0, pass cleared to 0.
  - busy=1 from cycle T+1.
- DRIVE: vector held for exactly SETTLE_CYCLES cycles.
  - Counter increments each cycle.
  - On the edge where counter = SETTLE_CYCLES-1: sample y; fail_mask[vec_idx] <= (y != EXPECTED[vec_idx]); counter <= 0.
  - If vec_idx=3, go to DONE; otherwise vec_idx <= vec_idx+1, which updates a/b on the same edge.
- DONE: one cycle.
  - done=1, busy=1, pass = (fail_mask==0), with the final vector's result included.
  - Next edge: IDLE, done=0, busy=0, a=b=0, vec_idx=0.
  - pass and fail_mask are retained.
- Latency: start sampled at edge T -> done high during cycle T+1+4*SETTLE_CYCLES. For SETTLE_CYCLES=10, done is high at T+41.
- start while busy (DRIVE/DONE) is ignored; it is not queued. start held continuously re-triggers a run the cycle after DONE returns to IDLE.
- Counter width is 8 bits. SETTLE_CYCLES=0 is illegal; the design must behave as SETTLE_CYCLES=1 (elaboration-time clamp).
- Reset asserted mid-run: immediate return to reset values, run discarded, no done pulse. After deassertion the block needs a fresh start.
- y is only sampled on the last settle cycle; glitches earlier in the window are ignored.

Test Plan:
1. Golden nand_gate as DUT, default parameters, start pulsed at T -> a/b step 00,01,10,11 every 10 cycles; done pulse at T+41 only; pass=1, fail_mask=4'b0000.
2. y tied to 1 (stuck-at-1), EXPECTED=4'b0111 -> fail_mask=4'b1000, pass=0.
3. and_gate as DUT, EXPECTED=4'b0111 -> fail_mask=4'b1111, pass=0. Rerun with EXPECTED=4'b1000 -> pass=1, fail_mask cleared at start and ending 4'b0000.
4. start re-pulsed at T+15 and T+30 during a run -> single done at T+41; no restart; vec_idx sequence unchanged.
5. rst_n pulled low while vec_idx=2 -> all outputs return to reset values asynchronously, no done pulse. Subsequent start completes normally with correct pass.
6. SETTLE_CYCLES=1, start at T -> vec_idx changes every cycle, done at T+5. Also verify y toggling during settle cycles 0..8 with correct value on cycle 9 (S=10) still yields pass=1.
